// File: rtl/display_mux.sv
// display_mux: registered multi-channel display selector with blanking on every channel switch.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   in_data   - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   sel       - manual channel request (ignored when out of range)
//   auto_mode - 1 = scan channels every DWELL cycles, 0 = follow sel
//   out       - selected channel data, zero while blanked
//   out_ch    - channel shown or being switched to
//   valid     - out carries channel data
//   switched  - one-cycle pulse when valid rises
module display_mux #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 2,
    parameter int DWELL    = 8,
    parameter int BLANK    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic                      auto_mode,
    output logic [WIDTH-1:0]          out,
    output logic [$clog2(CHANNELS)-1:0] out_ch,
    output logic                      valid,
    output logic                      switched
);
    localparam int SELW = $clog2(CHANNELS);
    localparam logic [SELW:0]   CH_LIM     = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] CH_LAST    = SELW'(CHANNELS - 1);
    localparam logic [7:0]      BLANK_INIT = 8'(BLANK - 1);
    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);

    typedef enum logic {S_SHOW, S_BLANK} state_t;

    state_t          state, state_n;
    logic [SELW-1:0] cur_ch, cur_ch_n, auto_tgt;
    logic [7:0]      bcnt, bcnt_n;
    logic [15:0]     dcnt, dcnt_n;
    logic [WIDTH-1:0] out_n, ch_data;
    logic            valid_n, switched_n, man_req, auto_req;

    assign ch_data  = in_data[int'(cur_ch)*WIDTH +: WIDTH];
    assign man_req  = !auto_mode && ({1'b0, sel} < CH_LIM) && (sel != cur_ch);
    assign auto_req = auto_mode && (state == S_SHOW) && (dcnt == DWELL_LAST);
    assign auto_tgt = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
    assign out_ch   = cur_ch;

    // A manual request also wins in BLANK, which restarts the blank interval.
    always_comb begin
        state_n    = state;
        cur_ch_n   = cur_ch;
        bcnt_n     = bcnt;
        dcnt_n     = '0;
        out_n      = '0;
        valid_n    = 1'b0;
        switched_n = 1'b0;
        if (man_req || auto_req) begin
            state_n  = S_BLANK;
            cur_ch_n = man_req ? sel : auto_tgt;
            bcnt_n   = BLANK_INIT;
        end else if (state == S_SHOW) begin
            out_n   = ch_data;
            valid_n = 1'b1;
            dcnt_n  = auto_mode ? dcnt + 16'd1 : '0;
        end else if (bcnt != 8'd0) begin
            bcnt_n = bcnt - 8'd1;
        end else begin
            state_n    = S_SHOW;
            out_n      = ch_data;
            valid_n    = 1'b1;
            switched_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_BLANK;
            cur_ch   <= '0;
            bcnt     <= BLANK_INIT;
            dcnt     <= '0;
            out      <= '0;
            valid    <= 1'b0;
            switched <= 1'b0;
        end else begin
            state    <= state_n;
            cur_ch   <= cur_ch_n;
            bcnt     <= bcnt_n;
            dcnt     <= dcnt_n;
            out      <= out_n;
            valid    <= valid_n;
            switched <= switched_n;
        end
    end
endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed checks of display_mux in default and 3-channel/DWELL=4 configurations.
module tb_display_mux;
    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [5:0] a_in;
    logic       a_sel, a_auto;
    logic [2:0] a_out;
    logic       a_out_ch, a_valid, a_sw;
    logic [8:0] b_in;
    logic [1:0] b_sel, b_out_ch;
    logic       b_auto;
    logic [2:0] b_out;
    logic       b_valid, b_sw;
    int         passed = 0, total = 0;
    logic       found;

    int exp_ch [18] = '{0,0,0,1,1,1,1,1,1,2,2,2,2,2,2,0,0,0};
    int exp_out[18] = '{1,1,1,0,0,2,2,2,2,0,0,6,6,6,6,0,0,1};
    int exp_v  [18] = '{1,1,1,0,0,1,1,1,1,0,0,1,1,1,1,0,0,1};
    int exp_s  [18] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0,0,1};

    display_mux dut_a (
        .clk(clk), .rst(rst_a), .in_data(a_in), .sel(a_sel), .auto_mode(a_auto),
        .out(a_out), .out_ch(a_out_ch), .valid(a_valid), .switched(a_sw)
    );

    display_mux #(.WIDTH(3), .CHANNELS(3), .DWELL(4), .BLANK(2)) dut_b (
        .clk(clk), .rst(rst_b), .in_data(b_in), .sel(b_sel), .auto_mode(b_auto),
        .out(b_out), .out_ch(b_out_ch), .valid(b_valid), .switched(b_sw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] o, input logic ch, input logic v, input logic s);
        chk({tag, "_out"}, 32'(a_out), 32'(o));
        chk({tag, "_ch"}, 32'(a_out_ch), 32'(ch));
        chk({tag, "_valid"}, 32'(a_valid), 32'(v));
        chk({tag, "_sw"}, 32'(a_sw), 32'(s));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] o, input logic [1:0] ch, input logic v, input logic s);
        chk({tag, "_out"}, 32'(b_out), 32'(o));
        chk({tag, "_ch"}, 32'(b_out_ch), 32'(ch));
        chk({tag, "_valid"}, 32'(b_valid), 32'(v));
        chk({tag, "_sw"}, 32'(b_sw), 32'(s));
    endtask

    initial begin
        a_in = {3'b100, 3'b101};
        a_sel = 1'b0;
        a_auto = 1'b0;
        b_in = {3'd6, 3'd2, 3'd1};
        b_sel = 2'd0;
        b_auto = 1'b0;
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        chk_a("a_rst_async", 3'd0, 1'b0, 1'b0, 1'b0);
        chk_b("b_rst_async", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_a("a_rst_held", 3'd0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        tick();
        chk_a("a_rel_e1", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("a_rel_e2", 3'b101, 1'b0, 1'b1, 1'b1);
        tick();
        chk_a("a_steady", 3'b101, 1'b0, 1'b1, 1'b0);
        a_in = {3'b100, 3'b011};
        tick();
        chk_a("a_latency", 3'b011, 1'b0, 1'b1, 1'b0);
        a_in = {3'b100, 3'b101};
        tick();
        a_sel = 1'b1;
        tick();
        chk_a("a_sw01_b1", 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_a("a_sw01_b2", 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_a("a_sw01_show", 3'b100, 1'b1, 1'b1, 1'b1);
        a_sel = 1'b0;
        tick();
        tick();
        tick();
        chk_a("a_back_ch0", 3'b101, 1'b0, 1'b1, 1'b1);
        a_sel = 1'b1;
        tick();
        chk_a("a_rs_b1", 3'd0, 1'b1, 1'b0, 1'b0);
        a_sel = 1'b0;
        tick();
        chk_a("a_rs_restart", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("a_rs_b2", 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("a_rs_show", 3'b101, 1'b0, 1'b1, 1'b1);

        rst_b = 1'b0;
        tick();
        chk_b("b_rel_e1", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_rel_e2", 3'd1, 2'd0, 1'b1, 1'b1);
        b_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_b("b_sel_oor", 3'd1, 2'd0, 1'b1, 1'b0);
        end
        b_auto = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk_b($sformatf("b_auto_e%0d", i + 1), 3'(exp_out[i]), 2'(exp_ch[i]), 1'(exp_v[i]), 1'(exp_s[i]));
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (b_out_ch == 2'd2) && b_valid;
        end
        chk("b_reach_ch2", 32'(found), 32'd1);
        tick();
        #3;
        rst_b = 1'b1;
        #1;
        chk_b("b_rst_mid", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();
        rst_b = 1'b0;
        tick();
        chk_b("b_rrel_e1", 3'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_rrel_e2", 3'd1, 2'd0, 1'b1, 1'b1);
        tick();
        chk_b("b_rrel_e3", 3'd1, 2'd0, 1'b1, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
